mem_byte_reader: RTL

//  Byte-serial readback engine for the four 16 KB matrix RAM banks filled by the byte-wise

---
 rtl/mem_byte_reader.sv | 109 ++++++++++
 1 files changed

// File: rtl/mem_byte_reader.sv
// Byte-serial readback of the four 16 KB matrix RAM banks, low byte first, valid/ready out.
// Latency start->first out_valid = RAM_LAT+2 cycles; stalls hold out_data/out_last until handshake.
module mem_byte_reader #(
  parameter int RAM_LAT = 1,
  parameter int CNT_W   = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      start_addr,
  input  logic [CNT_W-1:0] byte_count,
  output logic [12:0]      ram_addr,
  input  logic [3:0][15:0] ram_q,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] SEND  = 3'd3;
  localparam logic [2:0] FIN   = 3'd4;

  localparam logic [1:0]       WAIT_LAST = 2'(RAM_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [2:0]       state;
  logic [15:0]      cur_addr;
  logic [CNT_W-1:0] remaining;
  logic [1:0]       bank;
  logic [15:0]      word;
  logic [1:0]       wait_cnt;
  logic [12:0]      addr_q;
  logic             hs;

  // Address goes to the banks combinationally during FETCH so the RAM latency
  // starts counting in that cycle; afterwards the registered copy holds it.
  assign ram_addr  = (state == FETCH) ? cur_addr[13:1] : addr_q;
  assign out_valid = (state == SEND);
  assign out_data  = !out_valid ? 8'h00 : (cur_addr[0] ? word[15:8] : word[7:0]);
  assign out_last  = out_valid && (remaining == CNT_ONE);
  assign busy      = (state == FETCH) || (state == WAIT) || (state == SEND);
  assign done      = (state == FIN);
  assign hs        = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cur_addr  <= 16'h0000;
      remaining <= '0;
      bank      <= 2'd0;
      word      <= 16'h0000;
      wait_cnt  <= 2'd0;
      addr_q    <= 13'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (byte_count != '0) begin
              cur_addr  <= start_addr;
              remaining <= byte_count;
              state     <= FETCH;
            end else begin
              state <= FIN;
            end
          end
        end
        FETCH: begin
          addr_q   <= cur_addr[13:1];
          bank     <= cur_addr[15:14];
          wait_cnt <= 2'd0;
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            word  <= ram_q[bank];
            state <= SEND;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        SEND: begin
          if (hs) begin
            remaining <= remaining - CNT_ONE;
            cur_addr  <= cur_addr + 16'd1;
            // Low byte sent -> high byte of the same word is already in hand.
            if (remaining == CNT_ONE)
              state <= FIN;
            else if (!cur_addr[0])
              state <= SEND;
            else
              state <= FETCH;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
